// File: rtl/dmem_responder_pkg.sv
// Shared RV32 load/store definitions for the data-memory responder.
// Holds the funct3 mode codes, the latched request record and the load extension helpers.
package dmem_responder_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef struct packed {
    logic            we;
    logic [2:0]      mode;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } mem_req_t;

  function automatic logic [XLEN-1:0] ext_byte(input logic [7:0] b, input logic sgn);
    return {{(XLEN-8){sgn & b[7]}}, b};
  endfunction

  function automatic logic [XLEN-1:0] ext_half(input logic [15:0] h, input logic sgn);
    return {{(XLEN-16){sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_mode;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_we, req_mode, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_mode, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_responder_lane_align.sv
// Byte-lane steering for RV32 loads/stores: write strobe and replicated store data,
// extracted and extended load data, and misalignment/illegal-mode detection.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [2:0]      mode,
  input  logic [1:0]      addr_lo,
  input  logic            we,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rword,
  output logic [3:0]      strobe,
  output logic [XLEN-1:0] wdata_lanes,
  output logic [XLEN-1:0] rdata,
  output logic            err
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    rbyte = rword[7:0];
    case (addr_lo)
      2'd1:    rbyte = rword[15:8];
      2'd2:    rbyte = rword[23:16];
      2'd3:    rbyte = rword[31:24];
      default: rbyte = rword[7:0];
    endcase
  end

  assign rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    strobe      = '0;
    wdata_lanes = '0;
    rdata       = '0;
    err         = 1'b0;
    case (mode)
      MEM_B, MEM_BU: begin
        strobe      = 4'b0001 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
        rdata       = ext_byte(rbyte, mode == MEM_B);
        err         = we && (mode == MEM_BU);
      end
      MEM_H, MEM_HU: begin
        strobe      = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata[15:0]}};
        rdata       = ext_half(rhalf, mode == MEM_H);
        err         = addr_lo[0] || (we && (mode == MEM_HU));
      end
      MEM_W: begin
        strobe      = '1;
        wdata_lanes = wdata;
        rdata       = rword;
        err         = (addr_lo != 2'b00);
      end
      default: err = 1'b1;
    endcase
    // An erroring access must neither write nor return data.
    if (err) begin
      strobe = '0;
      rdata  = '0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one RV32 load/store at a time, waits WAIT_CYCLES,
// accesses the internal word RAM and returns extended load data or an error.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 1
)(
  input  logic              clk,
  input  logic              n_rst,
  dmem_responder_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e   state, state_nx;
  mem_req_t req_in, req_q, acc;
  logic [3:0] cnt;
  logic accept, enter_resp;

  logic [3:0]      strobe;
  logic [XLEN-1:0] wdata_lanes, lane_rdata;
  logic            lane_err;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_word;
  logic [ADDR_WIDTH-1:0] idx;
  logic [XLEN-ADDR_WIDTH-3:0] unused_addr_hi;

  always_comb begin
    req_in       = '0;
    req_in.we    = bus.req_we;
    req_in.mode  = bus.req_mode;
    req_in.addr  = bus.req_addr;
    req_in.wdata = bus.req_wdata;
  end

  // With WAIT_CYCLES==0 the RAM is accessed on the accept edge itself, so the
  // lane logic looks at the live request in IDLE and the latched one otherwise.
  assign acc            = (state == ST_IDLE) ? req_in : req_q;
  assign idx            = acc.addr[ADDR_WIDTH+1:2];
  assign unused_addr_hi = acc.addr[XLEN-1:ADDR_WIDTH+2];
  assign accept         = (state == ST_IDLE) && bus.req_valid;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (bus.req_valid) state_nx = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt == 4'd1)   state_nx = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign enter_resp = (state != ST_RESP) && (state_nx == ST_RESP);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      req_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        req_q <= req_in;
        cnt   <= 4'(WAIT_CYCLES);
      end else if (state == ST_WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  dmem_lane_align u_lane (
    .mode        (acc.mode),
    .addr_lo     (acc.addr[1:0]),
    .we          (acc.we),
    .wdata       (acc.wdata),
    .rword       (rd_word),
    .strobe      (strobe),
    .wdata_lanes (wdata_lanes),
    .rdata       (lane_rdata),
    .err         (lane_err)
  );

  always_ff @(posedge clk) begin
    if (enter_resp) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (acc.we && strobe[b]) mem[idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
      end
      rd_word <= mem[idx];
    end
  end

  assign bus.req_ready = (state == ST_IDLE);
  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_err   = bus.rsp_valid && lane_err;
  assign bus.rsp_rdata = (bus.rsp_valid && !acc.we) ? lane_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with one wait state, one with none.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic n_rst;
  logic use0;
  int unsigned n_asserts = 0;
  int unsigned n_fail    = 0;

  dmem_responder_if bus1 ();
  dmem_responder_if bus0 ();

  dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WAIT_CYCLES(1)) dut1 (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus1)
  );

  dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus0)
  );

  logic        o_req_ready, o_rsp_valid, o_rsp_err;
  logic [31:0] o_rsp_rdata;
  assign o_req_ready = use0 ? bus0.req_ready : bus1.req_ready;
  assign o_rsp_valid = use0 ? bus0.rsp_valid : bus1.rsp_valid;
  assign o_rsp_err   = use0 ? bus0.rsp_err   : bus1.rsp_err;
  assign o_rsp_rdata = use0 ? bus0.rsp_rdata : bus1.rsp_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [2:0] mode,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (use0) begin
      bus0.req_valid = v; bus0.req_we = we; bus0.req_mode = mode;
      bus0.req_addr  = addr; bus0.req_wdata = wdata;
    end else begin
      bus1.req_valid = v; bus1.req_we = we; bus1.req_mode = mode;
      bus1.req_addr  = addr; bus1.req_wdata = wdata;
    end
  endtask

  task automatic set_rsp_ready(input logic r);
    if (use0) bus0.rsp_ready = r;
    else      bus1.rsp_ready = r;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!o_rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_req(input string tag, input logic we, input logic [2:0] mode,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    @(negedge clk);
    check({tag, " req_ready"}, 32'(o_req_ready), 32'd1);
    drive(1'b1, we, mode, addr, wdata);
    @(negedge clk);
    drive(1'b0, ~we, 3'b111, ~addr, ~wdata);
    wait_rsp(lat);
    check({tag, " latency"}, 32'(lat), use0 ? 32'd1 : 32'd2);
    check({tag, " rdata"}, o_rsp_rdata, exp_rdata);
    check({tag, " err"}, 32'(o_rsp_err), 32'(exp_err));
    set_rsp_ready(1'b1);
    @(negedge clk);
    set_rsp_ready(1'b0);
    check({tag, " valid drop"}, 32'(o_rsp_valid), 32'd0);
    check({tag, " ready rise"}, 32'(o_req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    n_rst = 1'b1;
    use0  = 1'b1; drive(1'b0, 1'b0, MEM_W, '0, '0); set_rsp_ready(1'b0);
    use0  = 1'b0; drive(1'b0, 1'b0, MEM_W, '0, '0); set_rsp_ready(1'b0);
    #2 n_rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst ready",  32'(bus1.req_ready), 32'd1);
    check("rst valid",  32'(bus1.rsp_valid), 32'd0);
    check("rst rdata",  bus1.rsp_rdata,      32'd0);
    check("rst err",    32'(bus1.rsp_err),   32'd0);
    check("rst0 ready", 32'(bus0.req_ready), 32'd1);
    check("rst0 valid", 32'(bus0.rsp_valid), 32'd0);
    n_rst = 1'b1;

    do_req("SW 10",  1'b1, MEM_W,  32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    do_req("LB 13",  1'b0, MEM_B,  32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
    do_req("LBU 13", 1'b0, MEM_BU, 32'h13, 32'h0, 32'h000000DE, 1'b0);
    do_req("LH 10",  1'b0, MEM_H,  32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
    do_req("LHU 12", 1'b0, MEM_HU, 32'h12, 32'h0, 32'h0000DEAD, 1'b0);

    do_req("SB 11",  1'b1, MEM_B,  32'h11, 32'h000000AA, 32'h0, 1'b0);
    do_req("LW 10a", 1'b0, MEM_W,  32'h10, 32'h0, 32'hDEADAAEF, 1'b0);
    do_req("SH 12",  1'b1, MEM_H,  32'h12, 32'h00001234, 32'h0, 1'b0);
    do_req("LW 10b", 1'b0, MEM_W,  32'h10, 32'h0, 32'h1234AAEF, 1'b0);
    do_req("LB 12",  1'b0, MEM_B,  32'h12, 32'h0, 32'h00000034, 1'b0);
    do_req("LH 12",  1'b0, MEM_H,  32'h12, 32'h0, 32'h00001234, 1'b0);

    do_req("LW 12 err",  1'b0, MEM_W,  32'h12, 32'h0, 32'h0, 1'b1);
    do_req("LH 11 err",  1'b0, MEM_H,  32'h11, 32'h0, 32'h0, 1'b1);
    do_req("mode3 err",  1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
    do_req("SBU err",    1'b1, MEM_BU, 32'h10, 32'h000000FF, 32'h0, 1'b1);
    do_req("SW 11 err",  1'b1, MEM_W,  32'h11, 32'h55555555, 32'h0, 1'b1);
    do_req("LW 10c",     1'b0, MEM_W,  32'h10, 32'h0, 32'h1234AAEF, 1'b0);
    do_req("LW alias",   1'b0, MEM_W,  32'h00001010, 32'h0, 32'h1234AAEF, 1'b0);

    // Response back-pressure with a competing request presented during RESP.
    @(negedge clk);
    drive(1'b1, 1'b0, MEM_W, 32'h10, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, MEM_W, 32'h0, 32'h0);
    wait_rsp(lat);
    check("hold latency", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, MEM_W, 32'h10, 32'h0);
      check("hold valid", 32'(o_rsp_valid), 32'd1);
      check("hold rdata", o_rsp_rdata, 32'h1234AAEF);
      check("hold ready", 32'(o_req_ready), 32'd0);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, MEM_W, 32'h0, 32'h0);
    check("hold rdata last", o_rsp_rdata, 32'h1234AAEF);
    set_rsp_ready(1'b1);
    @(negedge clk);
    set_rsp_ready(1'b0);
    check("hold valid drop", 32'(o_rsp_valid), 32'd0);
    check("hold ready rise", 32'(o_req_ready), 32'd1);
    do_req("LW 10 post-hold", 1'b0, MEM_W, 32'h10, 32'h0, 32'h1234AAEF, 1'b0);

    // Reset in the middle of a pending store.
    do_req("SW 20", 1'b1, MEM_W, 32'h20, 32'h11223344, 32'h0, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b1, MEM_W, 32'h20, 32'hCAFEF00D);
    @(negedge clk);
    drive(1'b0, 1'b0, MEM_W, 32'h0, 32'h0);
    check("mid-wait ready", 32'(o_req_ready), 32'd0);
    #1 n_rst = 1'b0;
    #1;
    check("mid rst ready", 32'(o_req_ready), 32'd1);
    check("mid rst valid", 32'(o_rsp_valid), 32'd0);
    check("mid rst rdata", o_rsp_rdata,      32'd0);
    check("mid rst err",   32'(o_rsp_err),   32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    do_req("LW 20 after rst", 1'b0, MEM_W, 32'h20, 32'h0, 32'h11223344, 1'b0);

    // Zero-wait-state instance.
    use0 = 1'b1;
    do_req("W0 SW 40",  1'b1, MEM_W,  32'h40, 32'h55AA55AA, 32'h0, 1'b0);
    do_req("W0 LH 42",  1'b0, MEM_H,  32'h42, 32'h0, 32'h000055AA, 1'b0);
    do_req("W0 LB 40",  1'b0, MEM_B,  32'h40, 32'h0, 32'hFFFFFFAA, 1'b0);
    do_req("W0 LW 41",  1'b0, MEM_W,  32'h41, 32'h0, 32'h0, 1'b1);
    do_req("W0 LW 40",  1'b0, MEM_W,  32'h40, 32'h0, 32'h55AA55AA, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
